// File: rtl/freq_meter_core.sv
// Multi-channel reciprocal frequency meter with an SPI-driven readout path.
// Gated counts land in a live register; 0x3B starts a coherent 8-byte burst.
module freq_meter_core #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sig_clk_i,
    input  logic [NUM_CH-1:0] gate_en_i,
    output logic [NUM_CH-1:0] gate_sync_o,
    input  logic              dc_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    output logic [7:0]        reg_rd_data_o
);

    localparam int WW = 2 * CNT_W;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, READ} state_t;

    logic [2:0]       sig_sync;
    logic             sig_edge;
    logic             gate_open [NUM_CH];
    logic             wr_en     [NUM_CH];
    logic [CNT_W-1:0] sig_cnt   [NUM_CH];
    logic [CNT_W-1:0] ref_cnt   [NUM_CH];
    logic             any_wr;
    logic [WW-1:0]    sel_word;
    logic             reg_wr_en;
    logic [WW-1:0]    wr_data;
    logic [WW-1:0]    live;
    logic [WW-1:0]    shadow;
    logic [WW-1:0]    shadow_sh;
    state_t           state, state_nx;
    logic [2:0]       rd_addr, rd_addr_nx;
    logic             rd_req;
    logic             ctl_en, pipe_en;
    logic [2:0]       ctl_addr, pipe_addr;

    // bits 0..1 synchronise, bit 2 is the edge-detect history
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sig_sync <= '0;
        else            sig_sync <= {sig_sync[1:0], sig_clk_i};
    end

    assign sig_edge = sig_sync[1] & ~sig_sync[2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                gate_open[i] <= 1'b0;
                wr_en[i]     <= 1'b0;
                sig_cnt[i]   <= '0;
                ref_cnt[i]   <= '0;
            end else begin
                wr_en[i] <= 1'b0;
                if (!gate_open[i]) begin
                    if (gate_en_i[i] && sig_edge) begin
                        gate_open[i] <= 1'b1;
                        sig_cnt[i]   <= '0;
                        ref_cnt[i]   <= '0;
                    end
                end else begin
                    if (ref_cnt[i] != '1) ref_cnt[i] <= ref_cnt[i] + ONE;
                    if (sig_edge) begin
                        if (sig_cnt[i] != '1) sig_cnt[i] <= sig_cnt[i] + ONE;
                        if (!gate_en_i[i]) begin
                            gate_open[i] <= 1'b0;
                            wr_en[i]     <= 1'b1;
                        end
                    end
                end
            end
        end
        assign gate_sync_o[i] = gate_open[i];
    end

    // descending scan so the lowest requesting channel wins
    always_comb begin
        any_wr   = 1'b0;
        sel_word = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (wr_en[i]) begin
                any_wr   = 1'b1;
                sel_word = {sig_cnt[i], ref_cnt[i]};
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            reg_wr_en <= 1'b0;
            wr_data   <= '0;
        end else begin
            reg_wr_en <= any_wr;
            if (any_wr) wr_data <= sel_word;
        end
    end

    always_comb begin
        state_nx   = state;
        rd_req     = 1'b0;
        rd_addr_nx = rd_addr;
        if (spi_byte_vld_i) begin
            if (!dc_i) begin
                if (spi_byte_data_i == 8'h3B) begin
                    state_nx   = READ;
                    rd_req     = 1'b1;
                    rd_addr_nx = 3'd0;
                end else begin
                    state_nx = IDLE;
                end
            end else if (state == READ) begin
                rd_req     = 1'b1;
                rd_addr_nx = rd_addr + 3'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            rd_addr   <= 3'd0;
            ctl_en    <= 1'b0;
            ctl_addr  <= 3'd0;
            pipe_en   <= 1'b0;
            pipe_addr <= 3'd0;
        end else begin
            state     <= state_nx;
            rd_addr   <= rd_addr_nx;
            ctl_en    <= rd_req;
            ctl_addr  <= rd_addr_nx;
            pipe_en   <= ctl_en;
            pipe_addr <= ctl_addr;
        end
    end

    assign shadow_sh = shadow << {pipe_addr, 3'b000};

    // reads see the pre-write live value because both use old register state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            live          <= '0;
            shadow        <= '0;
            reg_rd_data_o <= 8'h00;
        end else begin
            if (reg_wr_en) live <= wr_data;
            if (pipe_en) begin
                if (pipe_addr == 3'd0) begin
                    shadow        <= live;
                    reg_rd_data_o <= live[WW-1 -: 8];
                end else begin
                    reg_rd_data_o <= shadow_sh[WW-1 -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_core.sv
// Randomised gate/readout bench for freq_meter_core with a time-based model.
// Expected counts come from elapsed signal time divided by the sys_clk period.
`timescale 1ns/1ps
module tb_freq_meter_core;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       sig_clk;
    logic [4:0] gate_en;
    logic [4:0] gate_sync;
    logic       dc;
    logic       spi_vld;
    logic [7:0] spi_data;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;
    int half_ns = 250;

    freq_meter_core dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .sig_clk_i      (sig_clk),
        .gate_en_i      (gate_en),
        .gate_sync_o    (gate_sync),
        .dc_i           (dc),
        .spi_byte_vld_i (spi_vld),
        .spi_byte_data_i(spi_data),
        .reg_rd_data_o  (rd_data)
    );

    initial sys_clk = 1'b0;
    always #2.4 sys_clk = ~sys_clk;

    // 0.1 ns offset keeps signal edges off sys_clk edges
    initial begin
        sig_clk = 1'b0;
        #0.1;
        forever #(half_ns) sig_clk = ~sig_clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // sys_clk cycles spanned by p signal periods: floor or ceil
    task automatic ref_range(input int p, input int h,
                             output int lo, output int hi);
        longint d;
        d  = longint'(p) * 2 * h * 1000;
        lo = int'(d / 4800);
        hi = int'((d + 4799) / 4800);
    endtask

    task automatic send_byte(input logic d_c, input logic [7:0] b);
        @(negedge sys_clk);
        dc       = d_c;
        spi_data = b;
        spi_vld  = 1'b1;
        @(negedge sys_clk);
        spi_vld = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic read_word(output logic [63:0] w);
        send_byte(1'b0, 8'h3B);
        w[63:56] = rd_data;
        for (int k = 1; k < 8; k++) begin
            send_byte(1'b1, 8'h00);
            w[63-8*k -: 8] = rd_data;
        end
    endtask

    task automatic set_half(input int h);
        @(negedge sig_clk);
        half_ns = h;
        @(posedge sig_clk);
    endtask

    task automatic run_gate(input int ch, input int p, input int h);
        logic [4:0] exp_gs;
        set_half(h);
        exp_gs = 5'(1 << ch);
        @(negedge sig_clk);
        gate_en[ch] = 1'b1;
        @(posedge sig_clk);
        #30;
        checks++;
        if (gate_sync !== exp_gs) begin
            errors++;
            $display("FAIL gate_open ch%0d: got %b want %b", ch, gate_sync, exp_gs);
        end
        repeat (p - 1) @(posedge sig_clk);
        @(negedge sig_clk);
        gate_en[ch] = 1'b0;
        @(posedge sig_clk);
        #60;
        checks++;
        if (gate_sync !== 5'b0) begin
            errors++;
            $display("FAIL gate_close ch%0d: got %b want 00000", ch, gate_sync);
        end
    endtask

    task automatic test_reset();
        logic [63:0] w;
        sys_rst_n = 1'b0;
        gate_en   = '0;
        dc        = 1'b0;
        spi_vld   = 1'b0;
        spi_data  = 8'h00;
        #23;
        checks++;
        if (gate_sync !== 5'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: gs=%b rd=%h want 0/00", gate_sync, rd_data);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1500;
        read_word(w);
        checks++;
        if (w !== 64'h0) begin
            errors++;
            $display("FAIL reset_no_write: got %h want 0", w);
        end
    endtask

    task automatic test_one_period();
        logic [63:0] w;
        int lo, hi;
        run_gate(0, 1, 250);
        ref_range(1, 250, lo, hi);
        read_word(w);
        checks++;
        if (w[63:32] !== 32'd1) begin
            errors++;
            $display("FAIL one_sig: got %0d want 1", w[63:32]);
        end
        checks++;
        if (int'(w[31:0]) < lo || int'(w[31:0]) > hi) begin
            errors++;
            $display("FAIL one_ref: got %0d want %0d..%0d", w[31:0], lo, hi);
        end
        send_byte(1'b1, 8'h00);
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL ninth_byte_msb: got %h want 00", rd_data);
        end
    endtask

    task automatic test_ten_periods();
        logic [63:0] w;
        int lo, hi;
        run_gate(0, 10, 250);
        ref_range(10, 250, lo, hi);
        read_word(w);
        checks++;
        if (w[63:32] !== 32'd10 || int'(w[31:0]) < lo || int'(w[31:0]) > hi) begin
            errors++;
            $display("FAIL ten_periods: got sig=%0d ref=%0d want 10 %0d..%0d",
                     w[63:32], w[31:0], lo, hi);
        end
    endtask

    task automatic test_random_gates();
        logic [63:0] w;
        int lo, hi, ch, p, h;
        for (int it = 0; it < 4; it++) begin
            ch = $urandom_range(0, 4);
            p  = $urandom_range(1, 5);
            h  = $urandom_range(40, 300);
            run_gate(ch, p, h);
            ref_range(p, h, lo, hi);
            read_word(w);
            checks++;
            if (w[63:32] !== 32'(p) || int'(w[31:0]) < lo || int'(w[31:0]) > hi) begin
                errors++;
                $display("FAIL random_gate ch%0d p%0d h%0d: got sig=%0d ref=%0d want %0d %0d..%0d",
                         ch, p, h, w[63:32], w[31:0], p, lo, hi);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] w;
        int lo, hi;
        set_half(250);
        @(negedge sig_clk);
        gate_en[3] = 1'b1;
        @(posedge sig_clk);
        @(posedge sig_clk);
        @(negedge sig_clk);
        gate_en[1] = 1'b1;
        @(posedge sig_clk);
        #30;
        checks++;
        if (gate_sync !== 5'b01010) begin
            errors++;
            $display("FAIL simul_open: got %b want 01010", gate_sync);
        end
        @(negedge sig_clk);
        gate_en[1] = 1'b0;
        gate_en[3] = 1'b0;
        @(posedge sig_clk);
        #60;
        ref_range(1, 250, lo, hi);
        read_word(w);
        checks++;
        if (w[63:32] !== 32'd1 || int'(w[31:0]) < lo || int'(w[31:0]) > hi) begin
            errors++;
            $display("FAIL simul_priority: got sig=%0d ref=%0d want 1 %0d..%0d",
                     w[63:32], w[31:0], lo, hi);
        end
    endtask

    task automatic test_coherent();
        logic [63:0] w;
        int lo, hi, lo2, hi2;
        send_byte(1'b0, 8'h3B);
        w[63:56] = rd_data;
        for (int k = 1; k < 4; k++) begin
            send_byte(1'b1, 8'h00);
            w[63-8*k -: 8] = rd_data;
        end
        run_gate(2, 3, 100);
        for (int k = 4; k < 8; k++) begin
            send_byte(1'b1, 8'h00);
            w[63-8*k -: 8] = rd_data;
        end
        ref_range(1, 250, lo, hi);
        checks++;
        if (w[63:32] !== 32'd1 || int'(w[31:0]) < lo || int'(w[31:0]) > hi) begin
            errors++;
            $display("FAIL coherent_old: got sig=%0d ref=%0d want 1 %0d..%0d",
                     w[63:32], w[31:0], lo, hi);
        end
        ref_range(3, 100, lo2, hi2);
        read_word(w);
        checks++;
        if (w[63:32] !== 32'd3 || int'(w[31:0]) < lo2 || int'(w[31:0]) > hi2) begin
            errors++;
            $display("FAIL coherent_new: got sig=%0d ref=%0d want 3 %0d..%0d",
                     w[63:32], w[31:0], lo2, hi2);
        end
    endtask

    task automatic test_bad_cmd();
        send_byte(1'b0, 8'h3B);
        for (int k = 1; k < 4; k++) send_byte(1'b1, 8'h00);
        checks++;
        if (rd_data !== 8'd3) begin
            errors++;
            $display("FAIL addr3_byte: got %h want 03", rd_data);
        end
        send_byte(1'b0, 8'h2A);
        for (int k = 0; k < 3; k++) begin
            send_byte(1'b1, 8'h00);
            checks++;
            if (rd_data !== 8'd3) begin
                errors++;
                $display("FAIL bad_cmd_hold %0d: got %h want 03", k, rd_data);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] w;
        run_gate(4, 2, 120);
        set_half(200);
        @(negedge sig_clk);
        gate_en[0] = 1'b1;
        @(posedge sig_clk);
        #77.3;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (gate_sync !== 5'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: gs=%b rd=%h want 0/00", gate_sync, rd_data);
        end
        gate_en = '0;
        #20;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1000;
        read_word(w);
        checks++;
        if (w !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_cleared: got %h want 0", w);
        end
    endtask

    initial begin
        test_reset();
        test_one_period();
        test_ten_periods();
        test_random_gates();
        test_simultaneous();
        test_coherent();
        test_bad_cmd();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
